// File: rtl/cms_pix28_package.sv
// ---------------------------------------------------------------------------
// cms_pix28_package
//   Shared types and constants for the pixel-chip test sequencer.
//   - seq_state_t : sequencer FSM states
//   - NUM_TESTS_C : number of test engines on the shared datapath
//   - test_number_1..test_number_5 : test numbers reported on active_test
//   - test_number(): maps a zero-based engine index to its test number
// ---------------------------------------------------------------------------
package cms_pix28_package;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        ABORT  = 3'd4
    } seq_state_t;

    localparam int NUM_TESTS_C = 5;

    // Width of the registered engine index (covers up to 8 engines).
    localparam int SEL_W = 3;

    localparam logic [3:0] test_number_1 = 4'd1;
    localparam logic [3:0] test_number_2 = 4'd2;
    localparam logic [3:0] test_number_3 = 4'd3;
    localparam logic [3:0] test_number_4 = 4'd4;
    localparam logic [3:0] test_number_5 = 4'd5;

    function automatic logic [3:0] test_number(input logic [SEL_W-1:0] idx);
        case (idx)
            3'd0:    return test_number_1;
            3'd1:    return test_number_2;
            3'd2:    return test_number_3;
            3'd3:    return test_number_4;
            3'd4:    return test_number_5;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/com_run_timer.sv
// ---------------------------------------------------------------------------
// com_run_timer
//   Saturating run-cycle counter plus timeout compare.
//   Ports:
//     clk, reset_n    : clock, asynchronous active-low reset
//     clear           : load 0 (takes priority over enable)
//     enable          : advance the counter by one (saturates at all-ones)
//     timeout_cycles  : run limit; 0 disables the timeout flag
//     count_next      : value the counter takes on the next enabled edge
//     timeout         : the next enabled edge brings the count to the limit
// ---------------------------------------------------------------------------
module com_run_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic [CNT_W-1:0] count_next,
    output logic             timeout
);

    logic [CNT_W-1:0] count;

    assign count_next = (&count) ? count : count + CNT_W'(1);

    // Compare against the incremented value so that the exit edge itself is
    // the one on which the count reaches timeout_cycles; the captured run
    // length then equals the limit exactly.
    assign timeout = (timeout_cycles != '0) && (count_next >= timeout_cycles);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/com_test_sequencer.sv
// ---------------------------------------------------------------------------
// com_test_sequencer
//   Grants the shared pixel-chip datapath to one test engine at a time,
//   supervises it until done or timeout, then releases the datapath.
//
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     op_code_w_reset   : synchronous abort + sticky-status clear (level)
//     test_enable_re    : start request pulses, bit i = test number i+1
//     timeout_cycles    : run limit in clk cycles, 0 = no timeout
//     test_done         : done pulses from the engines
//     test_run          : one-hot grant level (START and RUN only)
//     test_start        : one-cycle start pulse to the granted engine
//     test_abort        : one-cycle abort pulse to all engines
//     busy              : high in every state except IDLE
//     active_test       : granted test number, 0 in IDLE
//     status_done       : sticky, last run ended via test_done
//     status_timeout    : sticky, last run was killed by the timeout
//     status_collision  : sticky, a start request was dropped
//     run_cycles        : START+RUN cycle count of the last finished run
//     state             : current FSM state (debug visibility)
//
//   Handshake: there is no back-pressure. A request is a single-cycle pulse
//   on test_enable_re; it is either accepted in IDLE on the edge it is
//   sampled or dropped (and flagged as a collision). Engines answer with a
//   single-cycle test_done pulse while their test_run bit is high.
// ---------------------------------------------------------------------------
module com_test_sequencer
    import cms_pix28_package::*;
#(
    parameter int NUM_TESTS = NUM_TESTS_C,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_code_w_reset,
    input  logic [NUM_TESTS-1:0] test_enable_re,
    input  logic [CNT_W-1:0]     timeout_cycles,
    input  logic [NUM_TESTS-1:0] test_done,
    output logic [NUM_TESTS-1:0] test_run,
    output logic [NUM_TESTS-1:0] test_start,
    output logic                 test_abort,
    output logic                 busy,
    output logic [3:0]           active_test,
    output logic                 status_done,
    output logic                 status_timeout,
    output logic                 status_collision,
    output logic [CNT_W-1:0]     run_cycles,
    output seq_state_t           state
);

    seq_state_t       state_next;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] req_sel;
    logic             req_any;
    logic             req_multi;
    logic             accept;
    logic             timeout_hit;
    logic             counting;
    logic             leaving_run;
    logic             timeout_flag;
    logic [CNT_W-1:0] count_next;
    logic [NUM_TESTS-1:0] grant;

    // Lowest set request bit wins; scanning downward leaves the lowest index.
    always_comb begin
        req_sel = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (test_enable_re[i]) begin
                req_sel = SEL_W'(i);
            end
        end
        req_any   = |test_enable_re;
        // Clearing the lowest set bit leaves something only if >1 bit was set.
        req_multi = (test_enable_re & (test_enable_re - NUM_TESTS'(1))) != '0;
    end

    assign counting    = (state == START) || (state == RUN);
    assign leaving_run = counting && ((state_next == FINISH) || (state_next == ABORT));
    assign grant       = NUM_TESTS'(1) << sel;

    com_run_timer #(
        .CNT_W (CNT_W)
    ) u_run_timer (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (accept),
        .enable         (counting),
        .timeout_cycles (timeout_cycles),
        .count_next     (count_next),
        .timeout        (timeout_flag)
    );

    // Next-state logic. RUN exit priority: abort, done, timeout.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && !op_code_w_reset) begin
                    state_next = START;
                    accept     = 1'b1;
                end
            end
            START: begin
                state_next = op_code_w_reset ? ABORT : RUN;
            end
            RUN: begin
                if (op_code_w_reset) begin
                    state_next = ABORT;
                end else if (test_done[sel]) begin
                    state_next = FINISH;
                end else if (timeout_flag) begin
                    state_next  = ABORT;
                    timeout_hit = 1'b1;
                end
            end
            FINISH:  state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and grant index only.
    always_comb begin
        test_run    = '0;
        test_start  = '0;
        test_abort  = 1'b0;
        busy        = (state != IDLE);
        active_test = 4'd0;
        if (counting) begin
            test_run = grant;
        end
        if (state == START) begin
            test_start = grant;
        end
        if (state == ABORT) begin
            test_abort = 1'b1;
        end
        if (state != IDLE) begin
            active_test = test_number(sel);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            sel              <= '0;
            status_done      <= 1'b0;
            status_timeout   <= 1'b0;
            status_collision <= 1'b0;
            run_cycles       <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sel <= req_sel;
            end
            // The exit edge is also a counting edge, so capture the
            // incremented value; run_cycles is then valid in FINISH/ABORT.
            if (leaving_run) begin
                run_cycles <= count_next;
            end
            if (op_code_w_reset) begin
                status_done      <= 1'b0;
                status_timeout   <= 1'b0;
                status_collision <= 1'b0;
            end else begin
                if (accept) begin
                    status_done    <= 1'b0;
                    status_timeout <= 1'b0;
                end
                if (state == RUN && state_next == FINISH) begin
                    status_done <= 1'b1;
                end
                if (timeout_hit) begin
                    status_timeout <= 1'b1;
                end
                if ((state == IDLE && req_multi) || (state != IDLE && req_any)) begin
                    status_collision <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_com_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_com_test_sequencer
//   Directed and randomized runs of com_test_sequencer. Expected values come
//   from the rules of the sequencer: lowest request bit wins, a run lasts the
//   number of START+RUN cycles, done beats timeout, abort beats done.
// ---------------------------------------------------------------------------
module tb_com_test_sequencer;
    import cms_pix28_package::*;

    localparam int NT = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          op_code_w_reset = 1'b0;
    logic [NT-1:0] test_enable_re = '0;
    logic [CW-1:0] timeout_cycles = '0;
    logic [NT-1:0] test_done = '0;
    logic [NT-1:0] test_run;
    logic [NT-1:0] test_start;
    logic          test_abort;
    logic          busy;
    logic [3:0]    active_test;
    logic          status_done;
    logic          status_timeout;
    logic          status_collision;
    logic [CW-1:0] run_cycles;
    seq_state_t    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_coll   = 1'b0;

    com_test_sequencer #(.NUM_TESTS(NT), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .op_code_w_reset  (op_code_w_reset),
        .test_enable_re   (test_enable_re),
        .timeout_cycles   (timeout_cycles),
        .test_done        (test_done),
        .test_run         (test_run),
        .test_start       (test_start),
        .test_abort       (test_abort),
        .busy             (busy),
        .active_test      (active_test),
        .status_done      (status_done),
        .status_timeout   (status_timeout),
        .status_collision (status_collision),
        .run_cycles       (run_cycles),
        .state            (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_bit(input logic [NT-1:0] v);
        for (int i = 0; i < NT; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One complete run. d = RUN cycle (1-based) in which the granted engine
    // pulses done, t = timeout_cycles. The run lasts min(done, timeout) RUN
    // cycles plus the START cycle, which is what run_cycles must report.
    task automatic do_run(input logic [NT-1:0] req, input int d, input int t,
                          input bit use_done, input bit req_in_run);
        int            g;
        logic [NT-1:0] gv;
        int            k_to;
        int            k_end;
        bit            done_wins;
        logic [NT-1:0] noise;

        g         = lowest_bit(req);
        gv        = NT'(1) << g;
        k_to      = (t == 0) ? 1000000 : ((t <= 2) ? 1 : t - 1);
        done_wins = use_done && (d <= k_to);
        k_end     = done_wins ? d : k_to;

        timeout_cycles = CW'(t);
        test_enable_re = req;
        if ($countones(req) > 1) m_coll = 1'b1;
        step();
        test_enable_re = '0;
        check("start_pulse", test_start, gv);
        check("start_run", test_run, gv);
        check("start_active", active_test, g + 1);
        check("start_busy", busy, 1);
        check("start_done_clr", status_done, 0);
        check("start_to_clr", status_timeout, 0);
        check("start_coll", status_collision, m_coll);

        for (int k = 1; k <= k_end; k++) begin
            step();
            test_enable_re = '0;
            test_done      = '0;
            check("run_grant", test_run, gv);
            check("run_start_low", test_start, 0);
            // Done pulses from engines that do not hold the grant.
            noise = (NT'($urandom_range(0, 31)) | NT'(1) | NT'(16)) & ~gv;
            test_done = noise;
            if (k == k_end && done_wins) test_done = noise | gv;
            if (req_in_run && k == 1) begin
                test_enable_re = NT'($urandom_range(1, 31));
                m_coll = 1'b1;
            end
        end

        step();
        test_done      = '0;
        test_enable_re = '0;
        check("end_run_low", test_run, 0);
        check("end_busy", busy, 1);
        check("end_active", active_test, g + 1);
        check("end_run_cycles", run_cycles, k_end + 1);
        check("end_status_done", status_done, done_wins);
        check("end_status_timeout", status_timeout, !done_wins);
        check("end_abort", test_abort, !done_wins);

        step();
        check("idle_busy", busy, 0);
        check("idle_active", active_test, 0);
        check("idle_abort", test_abort, 0);
        check("idle_run_cycles", run_cycles, k_end + 1);
        check("idle_coll", status_collision, m_coll);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_state", state_dbg, IDLE);
        check("rst_run", test_run, 0);
        check("rst_start", test_start, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active_test, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_status", {status_done, status_timeout, status_collision}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // Test 3 finishes 10 cycles after its start pulse.
        do_run(5'b00100, 10, 0, 1'b1, 1'b0);

        // Timeout of 20 cycles, no done.
        do_run(NT'($urandom_range(1, 31)), 0, 20, 1'b0, 1'b0);

        // Two simultaneous requests, then a request dropped during RUN.
        do_run(5'b10010, 8, 0, 1'b1, 1'b1);

        // Test 3 runs while other engines pulse done; done and timeout tie.
        do_run(5'b00100, 30, 0, 1'b1, 1'b0);
        do_run(5'b01000, 6, 7, 1'b1, 1'b0);

        // Abort during RUN together with the granted engine's done.
        timeout_cycles = '0;
        test_enable_re = 5'b00001;
        step();
        test_enable_re = '0;
        step();
        step();
        step();
        op_code_w_reset = 1'b1;
        test_done       = 5'b00001;
        step();
        op_code_w_reset = 1'b0;
        test_done       = '0;
        m_coll          = 1'b0;
        check("op_abort_pulse", test_abort, 1);
        check("op_run_low", test_run, 0);
        check("op_status", {status_done, status_timeout, status_collision}, 0);
        check("op_run_cycles", run_cycles, 4);
        step();
        check("op_idle_abort", test_abort, 0);
        check("op_idle_busy", busy, 0);

        // Abort requested during the START cycle.
        test_enable_re = 5'b01000;
        step();
        test_enable_re  = '0;
        op_code_w_reset = 1'b1;
        step();
        op_code_w_reset = 1'b0;
        check("opst_abort", test_abort, 1);
        check("opst_active", active_test, 4);
        check("opst_run_cycles", run_cycles, 1);
        step();

        // Requests are blocked while the abort level is held in IDLE.
        op_code_w_reset = 1'b1;
        test_enable_re  = 5'b00011;
        step();
        check("opidle_busy", busy, 0);
        check("opidle_coll", status_collision, 0);
        op_code_w_reset = 1'b0;
        test_enable_re  = '0;
        step();
        check("opidle_still_idle", busy, 0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int  t;
            int  d;
            bit  ud;
            t  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, 30);
            d  = $urandom_range(1, 25);
            ud = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            do_run(NT'($urandom_range(1, 31)), d, t, ud, 1'($urandom_range(0, 1)));
        end

        // Long run with the timeout disabled.
        do_run(5'b10000, 2000, 0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        test_enable_re = 5'b00010;
        step();
        test_enable_re = '0;
        step();
        step();
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_state", state_dbg, IDLE);
        check("arst_run", test_run, 0);
        check("arst_busy", busy, 0);
        check("arst_active", active_test, 0);
        check("arst_run_cycles", run_cycles, 0);
        check("arst_status", {status_done, status_timeout, status_collision}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
